// File: rtl/sop_seq_datapath_pkg.sv
// sop_pkg: state encoding and width helpers for the sequential sum-of-products datapath
package sop_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int acc_w(input int w, input int n);
    return 2 * w + clog2(n + 1);
  endfunction
endpackage

// File: rtl/sop_seq_datapath_if.sv
// sop_seq_datapath_if: operand and result handshake bundle
interface sop_seq_datapath_if import sop_pkg::*; #(parameter int W = 16, parameter int N = 3);
  localparam int ACC_W = acc_w(W, N);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, c;
  logic [N*W-1:0] b;
  logic [W:0] sum, diff;
  logic [ACC_W-1:0] mac;
  modport master(output in_valid, a, b, c, out_ready, input in_ready, out_valid, sum, diff, mac);
  modport slave(input in_valid, a, b, c, out_ready, output in_ready, out_valid, sum, diff, mac);
endinterface

// File: rtl/sop_seq_datapath_mac_step.sv
// sop_mac_step: one multiply-accumulate step, acc + a*b_sel at full accumulator width
module sop_mac_step #(parameter int W = 16, parameter int ACC_W = 34) (
  input  logic [ACC_W-1:0] acc,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b_sel,
  output logic [ACC_W-1:0] nxt
);
  logic [2*W-1:0] p;
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b_sel};
  assign nxt = acc + {{(ACC_W-2*W){1'b0}}, p};
endmodule

// File: rtl/sop_seq_datapath.sv
// sop_seq_datapath: sum, difference and c + a*sum(b) with one product per cycle
module sop_seq_datapath import sop_pkg::*; #(parameter int W = 16, parameter int N = 3) (
  input logic clk,
  input logic rst_n,
  sop_seq_datapath_if.slave bus
);
  localparam int ACC_W = acc_w(W, N);
  localparam int IW = clog2(N);
  state_t state, nstate;
  logic [IW-1:0] idx;
  logic [W-1:0] ra, b_sel;
  logic [N*W-1:0] rb;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [W:0] sum_r, diff_r;
  logic last;
  assign last = idx == IW'(N - 1);
  always_comb
    nstate = (state == IDLE && bus.in_valid) ? ACC :
             (state == ACC && last) ? DONE :
             (state == DONE && bus.out_ready) ? IDLE : state;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.sum = sum_r;
  assign bus.diff = diff_r;
  assign bus.mac = acc;
  assign b_sel = rb[32'(idx) * W +: W];
  sop_mac_step #(.W(W), .ACC_W(ACC_W)) u_step (.acc(acc), .a(ra), .b_sel(b_sel), .nxt(acc_nxt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      sum_r <= '0;
      diff_r <= '0;
    end else begin
      state <= nstate;
      if (bus.in_valid && bus.in_ready) begin
        ra <= bus.a;
        rb <= bus.b;
        acc <= {{(ACC_W-W){1'b0}}, bus.c};
        idx <= '0;
        sum_r <= {1'b0, bus.a} + {1'b0, bus.b[W-1:0]};
        diff_r <= {1'b0, bus.b[2*W-1:W]} - {1'b0, bus.b[W-1:0]} - {1'b0, bus.a};
      end else if (state == ACC) begin
        acc <= acc_nxt;
        idx <= idx + 1'b1;
      end
    end
endmodule

// File: doc/sop_seq_datapath.md
# sop_seq_datapath

Parametrised, sequential sum-of-products datapath for the arithmetic-block family. For one operand set, it computes three results: a sum, a difference and the multiply-accumulate `mac = c + a*(b[0]+…+b[N-1])`. The products are formed one per cycle on a single shared multiplier, with valid/ready handshakes on both sides. It sits between an operand source and a result consumer that can each stall.

## Interface
Parameters:
- W, 16, operand width (unsigned).
- N, 3, number of b operands; legal range 2..16.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set; high only in IDLE.
- a  input  W  common multiplicand.
- b  input  N*W  packed operands; b[i] = b[i*W +: W].
- c  input  W  accumulator bias.
- out_valid  output  1  results valid; high only in DONE.
- out_ready  input  1  consumer accepts results.
- sum  output  W+1  result a + b[0].
- diff  output  W+1  result b[1] − b[0] − a, two's complement modulo 2^(W+1).
- mac  output  ACC_W  result c + Σ a·b[i], where ACC_W = 2W + clog2(N+1); 34 for the defaults.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ACC: counter idx runs 0..N−1.
  - DONE: out_valid=1.
- Accept happens on the edge where in_valid && in_ready. On that edge:
  - a, b and c are latched into internal registers.
  - sum and diff are computed from the inputs and registered.
  - acc ← zero-extended c, idx ← 0, state ← ACC.
- In ACC, each edge performs acc ← acc + a·b[idx] (full 2W-bit product, zero-extended) and idx ← idx+1.
  - When idx==N−1, state ← DONE.
- mac is the acc register itself. All arithmetic is unsigned, and mac cannot overflow at width ACC_W.
- In DONE, out_valid=1. The edge with out_ready=1 returns the block to IDLE.
- out_ready in any other state is ignored.
- in_valid outside IDLE is ignored; the operand source must hold its data until accepted.
- After the results are handed off, sum, diff and mac keep their last values until the next accept.
- They are undefined while in ACC; the bench checks them only when out_valid=1.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1 and out_valid=0.
  - sum=0, diff=0, mac=0, idx=0.
- Reset asserted at any point aborts the operation in progress immediately; no partial result is ever presented.
- Latency: out_valid rises N cycles after the accept edge (3 cycles for the defaults).
- Minimum initiation interval is N+2 cycles: accept edge, then N ACC edges, then the handoff edge, then IDLE.
- There is no accept in the same cycle as the handoff.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from the input ports.
- Simultaneous in_valid and out_ready in DONE: only the handoff occurs, and the new operand set is accepted in IDLE on the next cycle.

## Structure
- Package sop_pkg contains:
  - the state enum (IDLE, ACC, DONE);
  - a function acc_w(W,N) returning 2W+clog2(N+1);
  - the index-width function clog2(N).
- One sub-module, sop_mac_step: a combinational stage with inputs acc, a and b_sel, computing acc + a·b_sel at width ACC_W.
- The top level holds the FSM, the operand registers, the b mux selected by idx, and the result registers.

## Test plan
All scenarios use W=16, N=3.
- Basic: a=2, b={3,4,5}, c=7 → sum=5, diff=17'h1FFFF, mac=31.
  - out_valid is asserted exactly 3 cycles after the accept edge.
- Extremes: a, all b and c = 16'hFFFF → sum=17'h1FFFE, diff=17'h10001, mac=34'h2FFFB0002.
  - Also a=0, b={0,0,0}, c=0 → all results 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum, diff and mac stay stable and in_ready stays 0.
  - in_valid pulses during this time are ignored.
- Streaming: in_valid=1 and out_ready=1 continuously with 10 random operand sets → one result every 5 cycles.
  - Every result matches the reference model, in order.
- Reset mid-ACC: deassert rst_n asynchronously at idx=1.
  - All outputs go to 0 and in_ready goes to 1 immediately.
  - The next operand set (a=1, b={1,1,1}, c=0) → mac=3.
- Simultaneous event: in DONE, with in_valid=1 and out_ready=1 in the same cycle.
  - The handoff occurs, the block enters IDLE, and the waiting set is accepted on the following edge.
